// File: rtl/fpu_prefix_pkg.sv
// Shared definitions for the prefix adder/subtractor: operation encodings and
// prefix-tree depth.
package fpu_prefix_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ADDC = 2'b10;
  localparam logic [1:0] OP_SUBC = 2'b11;

  function automatic int prefix_levels(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/prefix_cell.sv
// One prefix-tree node combining a high span (index 1) with a low span (index 0).
// Grey nodes sit on spans that already reach bit 0, so only their generate matters.
module prefix_cell #(
  parameter bit GREY = 1'b0
) (
  input  logic [1:0] gin,
  input  logic [1:0] pin,
  output logic       gout,
  output logic       pout
);

  assign gout = gin[1] | (pin[1] & gin[0]);
  assign pout = GREY ? 1'b0 : (pin[1] & pin[0]);

endmodule

// File: rtl/exp_prefix_addsub_pipe.sv
// Pipelined Sklansky prefix adder/subtractor with valid/ready flow control,
// carry-in modes and carry/overflow/zero flags.
module exp_prefix_addsub_pipe
  import fpu_prefix_pkg::*;
#(
  parameter int WIDTH  = 14,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = prefix_levels(WIDTH);

  // Which pipeline register (if any) sits right after a given tree level.
  function automatic int boundary_stage(input int lvl);
    for (int k = 1; k < STAGES; k++) begin
      if ((k * LEVELS + STAGES - 1) / STAGES == lvl) return k;
    end
    return 0;
  endfunction

  for (genvar gi = 1; gi <= STAGES; gi++) begin : st
    logic v_reg;
    logic adv;
    logic load;

    if (gi == STAGES) begin : tail
      assign adv = v_reg & out_ready;
    end else begin : mid
      assign adv = v_reg & (st[gi+1].adv | ~st[gi+1].v_reg);
    end

    if (gi == 1) begin : head
      assign load = in_valid & in_ready;
    end else begin : feed
      assign load = st[gi-1].adv;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  v_reg <= 1'b0;
      else if (flush) v_reg <= 1'b0;
      else if (load)  v_reg <= 1'b1;
      else if (adv)   v_reg <= 1'b0;
    end
  end

  assign in_ready  = ~flush & (~st[1].v_reg | st[1].adv);
  assign out_valid = st[STAGES].v_reg;

  // pb_out carries the bitwise propagate, except bit 0 already holds p0^c0 so
  // the carry-in never has to travel down the pipe on its own.
  for (genvar gi = 0; gi <= LEVELS; gi++) begin : lv
    logic [WIDTH-1:0] g_out;
    logic [WIDTH-1:0] p_out;
    logic [WIDTH-1:0] pb_out;

    if (gi == 0) begin : pre
      logic [WIDTH-1:0] b_eff, p0, g0;
      logic             c0;
      assign b_eff  = op[0] ? ~b : b;
      assign c0     = op[1] ? cin : op[0];
      assign p0     = a ^ b_eff;
      assign g0     = a & b_eff;
      assign g_out  = {g0[WIDTH-1:1], g0[0] | (p0[0] & c0)};
      assign p_out  = p0;
      assign pb_out = {p0[WIDTH-1:1], p0[0] ^ c0};
    end else begin : tree
      localparam int D = gi - 1;
      localparam int K = boundary_stage(gi);
      logic [WIDTH-1:0] g_cmb, p_cmb;

      for (genvar gb = 0; gb < WIDTH; gb++) begin : bits
        if (((gb >> D) & 1) == 1) begin : node
          localparam int J = ((gb >> D) << D) - 1;
          prefix_cell #(.GREY(gb < (2 << D))) u_cell (
            .gin  ({lv[gi-1].g_out[gb], lv[gi-1].g_out[J]}),
            .pin  ({lv[gi-1].p_out[gb], lv[gi-1].p_out[J]}),
            .gout (g_cmb[gb]),
            .pout (p_cmb[gb])
          );
        end else begin : pass
          assign g_cmb[gb] = lv[gi-1].g_out[gb];
          assign p_cmb[gb] = lv[gi-1].p_out[gb];
        end
      end

      if (K != 0) begin : rg
        logic [WIDTH-1:0] g_reg, p_reg, pb_reg;
        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            g_reg  <= '0;
            p_reg  <= '0;
            pb_reg <= '0;
          end else if (st[K].load) begin
            g_reg  <= g_cmb;
            p_reg  <= p_cmb;
            pb_reg <= lv[gi-1].pb_out;
          end
        end
        assign g_out  = g_reg;
        assign p_out  = p_reg;
        assign pb_out = pb_reg;
      end else begin : wire_through
        assign g_out  = g_cmb;
        assign p_out  = p_cmb;
        assign pb_out = lv[gi-1].pb_out;
      end
    end
  end

  logic [WIDTH-1:0] g_fin, sum_next, sum_reg;
  logic             cout_next, ovf_next, zero_next;
  logic             cout_reg, ovf_reg, zero_reg;
  logic             unused_p_fin;

  assign g_fin        = lv[LEVELS].g_out;
  assign unused_p_fin = ^lv[LEVELS].p_out;
  assign sum_next     = lv[LEVELS].pb_out ^ {g_fin[WIDTH-2:0], 1'b0};
  assign cout_next    = g_fin[WIDTH-1];
  assign ovf_next     = g_fin[WIDTH-2] ^ g_fin[WIDTH-1];
  assign zero_next    = ~|sum_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
      zero_reg <= 1'b0;
    end else if (st[STAGES].load) begin
      sum_reg  <= sum_next;
      cout_reg <= cout_next;
      ovf_reg  <= ovf_next;
      zero_reg <= zero_next;
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;
  assign zero = zero_reg;

endmodule

// File: tb/tb_exp_prefix_addsub_pipe.sv
// Bench for exp_prefix_addsub_pipe: directed vectors, stall/reset/flush sequences
// and a randomised sweep over several WIDTH/STAGES configurations.
module tb_exp_prefix_addsub_pipe;
  import fpu_prefix_pkg::*;

  localparam int W = 14;
  localparam int S = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, flush, in_valid, in_ready, out_valid, out_ready, cin;
  logic         cout, ovf, zero;
  logic [W-1:0] a, b, sum;
  logic [1:0]   op;

  int checks = 0;
  int errors = 0;
  int sweep_done = 0;
  int main_outs = 0;

  exp_prefix_addsub_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  typedef struct {
    logic [1:0]   op;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
    logic         e_zero;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: integer sum a + b_eff + c0, with overflow judged on the exact signed value.
  function automatic res_t ref_add(input int w, input logic [63:0] aa, input logic [63:0] bb,
                                   input logic [1:0] o, input logic ci);
    res_t        r;
    logic [63:0] mask, av, be;
    logic [64:0] full;
    logic        c0;
    longint      sa, sb, ex, lim;
    mask = (64'd1 << w) - 64'd1;
    av   = aa & mask;
    be   = o[0] ? (~bb & mask) : (bb & mask);
    c0   = o[1] ? ci : o[0];
    full = {1'b0, av} + {1'b0, be} + {64'd0, c0};
    r.s  = full[63:0] & mask;
    r.co = full[w];
    sa   = longint'(av);
    sb   = longint'(be);
    if (av[w-1]) sa = sa - (longint'(1) << w);
    if (be[w-1]) sb = sb - (longint'(1) << w);
    ex   = sa + sb + (c0 ? 64'sd1 : 64'sd0);
    lim  = longint'(1) << (w - 1);
    r.ov = (ex >= lim) || (ex < -lim);
    r.z  = (r.s == 64'd0);
    return r;
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return mask;
      2:       return 64'd1 << (w - 1);
      3:       return 64'd1;
      default: return {$urandom, $urandom} & mask;
    endcase
  endfunction

  res_t exp_q[$];

  task automatic score_main();
    res_t r;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main_unexpected: got result sum=0x%0h, expected no result", sum);
      end else begin
        r = exp_q.pop_front();
        main_outs++;
        $display("main txn %0d: sum=0x%0h cout=%0b ovf=%0b zero=%0b", main_outs, sum, cout, ovf, zero);
        check("main_sum", 64'(sum), r.s);
        check("main_cout", 64'(cout), 64'(r.co));
        check("main_ovf", 64'(ovf), 64'(r.ov));
        check("main_zero", 64'(zero), 64'(r.z));
      end
    end
    if (in_valid && in_ready) exp_q.push_back(ref_add(W, 64'(a), 64'(b), op, cin));
  endtask

  task automatic cycle_main(input logic iv, input logic [W-1:0] aa, input logic [W-1:0] bb,
                            input logic [1:0] o, input logic ci, input logic ordy);
    @(posedge clk);
    #1;
    in_valid = iv; a = aa; b = bb; op = o; cin = ci; out_ready = ordy;
    #1;
    score_main();
  endtask

  task automatic run_one(input vec_t v, input string tag);
    int lat;
    cycle_main(1'b1, v.a, v.b, v.op, v.cin, 1'b1);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    lat = 0;
    do begin
      cycle_main(1'b0, '0, '0, OP_ADD, 1'b0, 1'b1);
      lat++;
    end while (!out_valid && lat < 10);
    check({tag, "_latency"}, 64'(lat), 64'(S));
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_sum"}, 64'(sum), 64'(v.e_sum));
    check({tag, "_cout"}, 64'(cout), 64'(v.e_cout));
    check({tag, "_ovf"}, 64'(ovf), 64'(v.e_ovf));
    check({tag, "_zero"}, 64'(zero), 64'(v.e_zero));
  endtask

  vec_t        vecs[12];
  logic [W-1:0] bp_a[4];
  logic [W-1:0] bp_b[4];

  initial begin
    int           idx, t;
    logic [W-1:0] hold;

    vecs[0]  = '{OP_ADD,  1'b0, 14'h1FFF, 14'h0001, 14'h2000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{OP_ADD,  1'b0, 14'h3FFF, 14'h0001, 14'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{OP_SUB,  1'b0, 14'h0005, 14'h0005, 14'h0000, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{OP_SUB,  1'b0, 14'h0003, 14'h0005, 14'h3FFE, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{OP_SUBC, 1'b0, 14'h0010, 14'h0001, 14'h000E, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{OP_ADDC, 1'b1, 14'h0010, 14'h0001, 14'h0012, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{OP_ADD,  1'b0, 14'h2000, 14'h2000, 14'h0000, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{OP_SUB,  1'b0, 14'h2000, 14'h0001, 14'h1FFF, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{OP_ADD,  1'b1, 14'h0001, 14'h0001, 14'h0002, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{OP_SUB,  1'b0, 14'h0001, 14'h0000, 14'h0001, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{OP_SUBC, 1'b1, 14'h0010, 14'h0001, 14'h000F, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{OP_ADDC, 1'b0, 14'h3FFF, 14'h3FFF, 14'h3FFE, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = W'($urandom);
      bp_b[i] = W'($urandom);
    end

    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; op = OP_ADD; cin = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_flags", {61'd0, cout, ovf, zero}, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 12; i++) run_one(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: only STAGES bundles fit while the consumer stalls.
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      cycle_main(idx < 4, bp_a[idx % 4], bp_b[idx % 4], OP_ADD, 1'b0, 1'b0);
      if (in_ready && idx < 4) idx++;
    end
    check("bp_accepted", 64'(idx), 64'(S));
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    hold = sum;
    for (int c = 0; c < 3; c++) begin
      cycle_main(1'b1, bp_a[idx % 4], bp_b[idx % 4], OP_ADD, 1'b0, 1'b0);
      check("bp_hold_sum", 64'(sum), 64'(hold));
      check("bp_hold_valid", 64'(out_valid), 64'd1);
    end
    main_outs = 0;
    t = 0;
    while (main_outs < 4 && t < 20) begin
      cycle_main(idx < 4, bp_a[idx % 4], bp_b[idx % 4], OP_ADD, 1'b0, 1'b1);
      if (in_ready && idx < 4) idx++;
      t++;
    end
    check("bp_received", 64'(main_outs), 64'd4);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with work in flight.
    cycle_main(1'b1, 14'h0123, 14'h0456, OP_ADD, 1'b0, 1'b0);
    cycle_main(1'b1, 14'h0777, 14'h0001, OP_SUB, 1'b0, 1'b0);
    cycle_main(1'b0, '0, '0, OP_ADD, 1'b0, 1'b0);
    check("rstmid_pre_valid", 64'(out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rstmid_out_valid", 64'(out_valid), 64'd0);
    check("rstmid_sum", 64'(sum), 64'd0);
    check("rstmid_flags", {61'd0, cout, ovf, zero}, 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle_main(1'b0, '0, '0, OP_ADD, 1'b0, 1'b1);
      check("rstmid_idle_valid", 64'(out_valid), 64'd0);
      check("rstmid_in_ready", 64'(in_ready), 64'd1);
    end
    run_one(vecs[0], "post_rst");

    // Flush with work in flight and a bundle offered during the flush cycle.
    cycle_main(1'b1, 14'h0A0A, 14'h0101, OP_ADD, 1'b0, 1'b0);
    cycle_main(1'b1, 14'h0B0B, 14'h0202, OP_ADD, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; a = 14'h1111; b = 14'h2222; op = OP_ADD; out_ready = 1'b0;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'd0);
    score_main();
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    for (int c = 0; c < 3; c++) begin
      cycle_main(1'b0, '0, '0, OP_ADD, 1'b0, 1'b1);
      check("flush_idle_valid", 64'(out_valid), 64'd0);
    end
    run_one(vecs[3], "post_flush");

    // Random traffic with random backpressure.
    for (int c = 0; c < 400; c++) begin
      cycle_main($urandom_range(0, 3) != 0, W'(pick(W)), W'(pick(W)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      cycle_main(1'b0, '0, '0, OP_ADD, 1'b0, 1'b1);
      t++;
    end
    check("rand_drain", 64'(exp_q.size()), 64'd0);

    t = 0;
    while (sweep_done < 12 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    check("sweep_complete", 64'(sweep_done), 64'd12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  for (genvar gi = 0; gi < 12; gi++) begin : sw
    localparam int SW = (gi < 3) ? 8 : ((gi < 7) ? 14 : 32);
    localparam int SS = (gi < 3) ? (gi + 1) : ((gi < 7) ? (gi - 2) : (gi - 6));

    logic          s_rn, s_fl, s_iv, s_ir, s_ov, s_or, s_ci, s_co, s_of, s_zr;
    logic [SW-1:0] s_a, s_b, s_sum;
    logic [1:0]    s_op;

    exp_prefix_addsub_pipe #(.WIDTH(SW), .STAGES(SS)) u_dut (
      .clk       (clk),
      .reset_n   (s_rn),
      .flush     (s_fl),
      .in_valid  (s_iv),
      .in_ready  (s_ir),
      .a         (s_a),
      .b         (s_b),
      .op        (s_op),
      .cin       (s_ci),
      .out_valid (s_ov),
      .out_ready (s_or),
      .sum       (s_sum),
      .cout      (s_co),
      .ovf       (s_of),
      .zero      (s_zr)
    );

    initial begin
      res_t q[$];
      res_t r;
      int   outs, t;
      outs = 0;
      s_rn = 1'b1; s_fl = 1'b0; s_iv = 1'b0; s_or = 1'b0;
      s_a = '0; s_b = '0; s_op = OP_ADD; s_ci = 1'b0;
      #2 s_rn = 1'b0;
      repeat (2) @(posedge clk);
      #1 s_rn = 1'b1;
      for (int c = 0; c < 300 + 20; c++) begin
        @(posedge clk);
        #1;
        if (c < 300) begin
          s_iv = $urandom_range(0, 3) != 0;
          s_a  = SW'(pick(SW));
          s_b  = SW'(pick(SW));
          s_op = 2'($urandom_range(0, 3));
          s_ci = 1'($urandom_range(0, 1));
          s_or = $urandom_range(0, 3) != 0;
          s_fl = $urandom_range(0, 49) == 0;
        end else begin
          s_iv = 1'b0; s_or = 1'b1; s_fl = 1'b0;
        end
        #1;
        if (s_ov && s_or) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sw%0d_unexpected: got result sum=0x%0h, expected no result", gi, s_sum);
          end else begin
            r = q.pop_front();
            outs++;
            $display("sw%0d W=%0d S=%0d txn %0d: sum=0x%0h cout=%0b ovf=%0b zero=%0b",
                     gi, SW, SS, outs, s_sum, s_co, s_of, s_zr);
            check($sformatf("sw%0d_sum", gi), 64'(s_sum), r.s);
            check($sformatf("sw%0d_flags", gi), {61'd0, s_co, s_of, s_zr}, {61'd0, r.co, r.ov, r.z});
          end
        end
        if (s_fl) begin
          check($sformatf("sw%0d_flush_in_ready", gi), 64'(s_ir), 64'd0);
          q.delete();
        end
        if (s_iv && s_ir) q.push_back(ref_add(SW, 64'(s_a), 64'(s_b), s_op, s_ci));
      end
      check($sformatf("sw%0d_drain", gi), 64'(q.size()), 64'd0);
      t = outs;
      check($sformatf("sw%0d_some_output", gi), 64'(t > 0), 64'd1);
      sweep_done++;
    end
  end

endmodule
